bias_ctrl: RTL and testbench

BIAS_CTRL -- requirements
Module: bias_ctrl

---
 rtl/vpu_pkg.sv | 17 +
 rtl/bias_ctrl_bank.sv | 43 ++++
 rtl/bias_ctrl.sv | 156 +++++++++++++++
 tb/tb_bias_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - shared VPU typedefs and helpers
package vpu_pkg;

   // Bias controller job phases
   typedef enum logic [1:0] {
      BC_IDLE  = 2'd0,
      BC_FETCH = 2'd1,
      BC_ARMED = 2'd2,
      BC_DONE  = 2'd3
   } bias_ctrl_state_e;

   // Index width for a table of n entries; never narrower than one bit
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bias_ctrl_bank.sv
// rtl/bias_ctrl_bank.sv - per-column bias register file with flat read port
module bias_bank
   import vpu_pkg::*;
#(
   parameter int NUM_COLS   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = idx_width(NUM_COLS)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           we_in,
   input  logic [IDX_W-1:0]               idx_in,
   input  logic [DATA_WIDTH-1:0]          data_in,
   input  logic                           clr_in,
   output logic [NUM_COLS*DATA_WIDTH-1:0] bank_out
);

   logic [DATA_WIDTH-1:0] r_mem [NUM_COLS];

   // Clear wins over write; entries otherwise hold until rewritten
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_COLS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (clr_in) begin
         for (int i = 0; i < NUM_COLS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (we_in) begin
         for (int i = 0; i < NUM_COLS; i++) begin
            if (IDX_W'(i) == idx_in) begin
               r_mem[i] <= data_in;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_COLS; g++) begin : g_flat
      assign bank_out[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
   end

endmodule

// File: rtl/bias_ctrl.sv
// rtl/bias_ctrl.sv - fetches per-column bias from UB and gates a row job
module bias_ctrl
   import vpu_pkg::*;
#(
   parameter int NUM_COLS   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int ROW_WIDTH  = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start_in,
   input  logic                           bias_en_in,
   input  logic [ADDR_WIDTH-1:0]          bias_base_addr_in,
   input  logic [ROW_WIDTH-1:0]           num_rows_in,
   output logic                           ub_rd_req_out,
   output logic [ADDR_WIDTH-1:0]          ub_rd_addr_out,
   input  logic                           ub_rd_ack_in,
   input  logic [DATA_WIDTH-1:0]          ub_rd_data_in,
   input  logic                           row_valid_in,
   output logic [NUM_COLS*DATA_WIDTH-1:0] bias_scalar_out,
   output logic                           busy_out,
   output logic                           ready_out,
   output logic                           done_out,
   output logic                           err_out
);

   localparam int               COL_W    = idx_width(NUM_COLS);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

   bias_ctrl_state_e      r_state;
   logic [COL_W-1:0]      r_col;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ROW_WIDTH-1:0]  r_rows;
   logic [ROW_WIDTH-1:0]  r_row_cnt;
   logic                  r_req;
   logic                  r_busy;
   logic                  r_ready;
   logic                  r_done;
   logic                  r_err;

   logic                  w_start_ok;
   logic                  w_ack;
   logic                  w_bank_clr;

   // Only an ack against a live request counts; stray acks are dropped
   assign w_start_ok = start_in && (r_state == BC_IDLE);
   assign w_ack      = ub_rd_ack_in && r_req;
   assign w_bank_clr = w_start_ok && !bias_en_in;

   assign ub_rd_req_out  = r_req;
   assign ub_rd_addr_out = r_base + ADDR_WIDTH'(r_col);
   assign busy_out       = r_busy;
   assign ready_out      = r_ready;
   assign done_out       = r_done;
   assign err_out        = r_err;

   bias_bank #(
      .NUM_COLS   (NUM_COLS),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (COL_W)
   ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_in    (w_ack),
      .idx_in   (r_col),
      .data_in  (ub_rd_data_in),
      .clr_in   (w_bank_clr),
      .bank_out (bias_scalar_out)
   );

   // Job FSM with registered status outputs; misuse flag overrides the start clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= BC_IDLE;
         r_col     <= '0;
         r_base    <= '0;
         r_rows    <= '0;
         r_row_cnt <= '0;
         r_req     <= 1'b0;
         r_busy    <= 1'b0;
         r_ready   <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            BC_IDLE: begin
               r_done <= 1'b0;
               if (w_start_ok) begin
                  r_base    <= bias_base_addr_in;
                  r_rows    <= num_rows_in;
                  r_col     <= '0;
                  r_row_cnt <= '0;
                  r_err     <= 1'b0;
                  if (bias_en_in) begin
                     r_state <= BC_FETCH;
                     r_req   <= 1'b1;
                     r_busy  <= 1'b1;
                  end else if (num_rows_in != '0) begin
                     r_state <= BC_ARMED;
                     r_busy  <= 1'b1;
                     r_ready <= 1'b1;
                  end else begin
                     r_state <= BC_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            BC_FETCH: begin
               if (w_ack) begin
                  if (r_col == LAST_COL) begin
                     r_col <= '0;
                     r_req <= 1'b0;
                     if (r_rows != '0) begin
                        r_state <= BC_ARMED;
                        r_ready <= 1'b1;
                     end else begin
                        r_state <= BC_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  end else begin
                     r_col <= r_col + COL_W'(1);
                  end
               end
            end
            BC_ARMED: begin
               if (row_valid_in) begin
                  r_row_cnt <= r_row_cnt + ROW_WIDTH'(1);
                  if (r_row_cnt == r_rows - ROW_WIDTH'(1)) begin
                     r_state <= BC_DONE;
                     r_busy  <= 1'b0;
                     r_ready <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            BC_DONE: begin
               r_done  <= 1'b0;
               r_state <= BC_IDLE;
            end
            default: begin
               r_state <= BC_IDLE;
               r_req   <= 1'b0;
               r_busy  <= 1'b0;
               r_ready <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
         if (row_valid_in && (r_state != BC_ARMED)) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bias_ctrl.sv
// tb/tb_bias_ctrl.sv - directed self-checking bench for bias_ctrl
module tb_bias_ctrl;
   import vpu_pkg::*;

   logic         clk;
   logic         rst_n;
   logic         start_in;
   logic         bias_en_in;
   logic [15:0]  bias_base_addr_in;
   logic [15:0]  num_rows_in;
   logic         ub_rd_req_out;
   logic [15:0]  ub_rd_addr_out;
   logic         ub_rd_ack_in;
   logic [31:0]  ub_rd_data_in;
   logic         row_valid_in;
   logic [127:0] bias_scalar_out;
   logic         busy_out;
   logic         ready_out;
   logic         done_out;
   logic         err_out;

   int           total;
   int           bad;
   logic [15:0]  addr_q [$];
   logic [127:0] bias_q [$];
   logic [127:0] held_bias;

   bias_ctrl #(
      .NUM_COLS   (4),
      .DATA_WIDTH (32),
      .ADDR_WIDTH (16),
      .ROW_WIDTH  (16)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start_in          (start_in),
      .bias_en_in        (bias_en_in),
      .bias_base_addr_in (bias_base_addr_in),
      .num_rows_in       (num_rows_in),
      .ub_rd_req_out     (ub_rd_req_out),
      .ub_rd_addr_out    (ub_rd_addr_out),
      .ub_rd_ack_in      (ub_rd_ack_in),
      .ub_rd_data_in     (ub_rd_data_in),
      .row_valid_in      (row_valid_in),
      .bias_scalar_out   (bias_scalar_out),
      .busy_out          (busy_out),
      .ready_out         (ready_out),
      .done_out          (done_out),
      .err_out           (err_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Fetch job against a UB model that acks column k after w[k] wait cycles
   task automatic run_fetch(input logic [15:0] base, input logic [15:0] rows,
                            input logic [127:0] dv, input int w0, input int w1,
                            input int w2, input int w3, input logic err_row);
      int          w [4];
      logic [15:0] a;
      w = '{w0, w1, w2, w3};
      for (int k = 0; k < 4; k++) begin
         a = base + 16'(k);
         addr_q.push_back(a);
      end
      bias_q.push_back(dv);
      @(negedge clk);
      start_in = 1'b1; bias_en_in = 1'b1;
      bias_base_addr_in = base; num_rows_in = rows;
      @(negedge clk);
      start_in = 1'b0;
      row_valid_in = err_row;
      for (int k = 0; k < 4; k++) begin
         ub_rd_ack_in = 1'b0;
         for (int j = 0; j < w[k]; j++) begin
            check("req_wait", ub_rd_req_out, 1'b1);
            check("addr_hold", ub_rd_addr_out, addr_q[0]);
            @(negedge clk);
            row_valid_in = 1'b0;
         end
         ub_rd_ack_in = 1'b1;
         ub_rd_data_in = dv[k*32 +: 32];
         check("addr", ub_rd_addr_out, addr_q.pop_front());
         @(negedge clk);
         row_valid_in = 1'b0;
         ub_rd_ack_in = 1'b0;
      end
      check("ready_after_fetch", ready_out, 1'b1);
      check("req_after_fetch", ub_rd_req_out, 1'b0);
      check("bias_loaded", bias_scalar_out, bias_q.pop_front());
   endtask

   // Bounded wait for the job-complete pulse
   task automatic wait_done(input int max_cycles);
      int c;
      c = 0;
      while (done_out !== 1'b1 && c < max_cycles) begin
         @(negedge clk);
         c++;
      end
      check("done_seen", done_out, 1'b1);
      check("busy_with_done", busy_out, 1'b0);
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0; start_in = 1'b0; bias_en_in = 1'b0;
      bias_base_addr_in = '0; num_rows_in = '0;
      ub_rd_ack_in = 1'b0; ub_rd_data_in = '0; row_valid_in = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req", ub_rd_req_out, 1'b0);
      check("rst_addr", ub_rd_addr_out, 16'h0);
      check("rst_busy", busy_out, 1'b0);
      check("rst_ready", ready_out, 1'b0);
      check("rst_done", done_out, 1'b0);
      check("rst_err", err_out, 1'b0);
      check("rst_bias", bias_scalar_out, 128'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Fetch with mixed wait states, then rows 1,0,1,1
      run_fetch(16'h00FE, 16'd3, {32'd100, 32'd7, 32'hFFFF_FFFD, 32'd10}, 0, 2, 0, 1, 1'b0);
      held_bias = {32'd100, 32'd7, 32'hFFFF_FFFD, 32'd10};
      row_valid_in = 1'b1;
      @(negedge clk); row_valid_in = 1'b0;
      @(negedge clk); row_valid_in = 1'b1;
      @(negedge clk); row_valid_in = 1'b1;
      check("no_early_done", done_out, 1'b0);
      @(negedge clk); row_valid_in = 1'b0;
      check("rows_done", done_out, 1'b1);
      check("rows_busy_low", busy_out, 1'b0);
      check("rows_ready_low", ready_out, 1'b0);
      check("rows_bias_held", bias_scalar_out, held_bias);
      @(negedge clk);
      check("done_single", done_out, 1'b0);
      check("idle_bias_held", bias_scalar_out, held_bias);

      // Stray ack in IDLE must not write the bank
      ub_rd_ack_in = 1'b1; ub_rd_data_in = 32'hDEAD_BEEF;
      @(negedge clk); ub_rd_ack_in = 1'b0;
      @(negedge clk);
      check("stray_ack", bias_scalar_out, held_bias);

      // Address wrap
      run_fetch(16'hFFFE, 16'd1, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, 0, 0, 1'b0);
      row_valid_in = 1'b1;
      @(negedge clk); row_valid_in = 1'b0;
      wait_done(4);
      @(negedge clk);

      // Bypass with two rows
      start_in = 1'b1; bias_en_in = 1'b0; num_rows_in = 16'd2;
      @(negedge clk); start_in = 1'b0;
      check("byp_ready", ready_out, 1'b1);
      check("byp_busy", busy_out, 1'b1);
      check("byp_req", ub_rd_req_out, 1'b0);
      check("byp_bias", bias_scalar_out, 128'h0);
      row_valid_in = 1'b1;
      @(negedge clk);
      check("byp_no_early_done", done_out, 1'b0);
      @(negedge clk); row_valid_in = 1'b0;
      check("byp_done", done_out, 1'b1);
      @(negedge clk);

      // Bypass with zero rows
      start_in = 1'b1; bias_en_in = 1'b0; num_rows_in = 16'd0;
      @(negedge clk); start_in = 1'b0;
      check("zero_rows_done", done_out, 1'b1);
      check("zero_rows_busy", busy_out, 1'b0);
      @(negedge clk);
      check("zero_rows_single", done_out, 1'b0);

      // Row during FETCH flags err; start during ARMED ignored
      run_fetch(16'h0010, 16'd2, {32'h4, 32'h3, 32'h2, 32'h1}, 1, 0, 0, 0, 1'b1);
      check("err_set", err_out, 1'b1);
      start_in = 1'b1; bias_en_in = 1'b0; num_rows_in = 16'd5;
      @(negedge clk); start_in = 1'b0;
      check("armed_start_ignored", ready_out, 1'b1);
      check("armed_bias_kept", bias_scalar_out, {32'h4, 32'h3, 32'h2, 32'h1});
      row_valid_in = 1'b1;
      @(negedge clk);
      check("misuse_no_early_done", done_out, 1'b0);
      @(negedge clk); row_valid_in = 1'b0;
      check("misuse_done", done_out, 1'b1);
      @(negedge clk);
      check("err_sticky", err_out, 1'b1);
      start_in = 1'b1; bias_en_in = 1'b0; num_rows_in = 16'd0;
      @(negedge clk); start_in = 1'b0;
      check("err_cleared", err_out, 1'b0);
      @(negedge clk);

      // Asynchronous reset mid-FETCH at column 2
      start_in = 1'b1; bias_en_in = 1'b1; bias_base_addr_in = 16'h0200; num_rows_in = 16'd4;
      @(negedge clk);
      start_in = 1'b0; row_valid_in = 1'b1;
      ub_rd_ack_in = 1'b1; ub_rd_data_in = 32'd1;
      @(negedge clk);
      row_valid_in = 1'b0; ub_rd_data_in = 32'd2;
      @(negedge clk);
      ub_rd_ack_in = 1'b0;
      check("pre_rst_addr", ub_rd_addr_out, 16'h0202);
      check("pre_rst_err", err_out, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_req", ub_rd_req_out, 1'b0);
      check("arst_busy", busy_out, 1'b0);
      check("arst_bias", bias_scalar_out, 128'h0);
      check("arst_err", err_out, 1'b0);
      check("arst_state", dut.r_state, BC_IDLE);
      @(negedge clk);
      rst_n = 1'b1;

      // First job after reset release
      start_in = 1'b1; bias_en_in = 1'b0; num_rows_in = 16'd0;
      @(negedge clk); start_in = 1'b0;
      check("post_rst_done", done_out, 1'b1);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
